// File: rtl/dmem_port_arbiter.sv
// Two-lane data-memory port arbiter: serialises lane 1 / lane 2 load-store requests onto one port.
// Optional wait-timeout abort is built when DMEM_ARB_TIMEOUT_EN is defined.
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              req2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata2,
    output logic              ack2,
    output logic [DATA_W-1:0] rdata2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS1 = 2'd1,
        BUS2 = 2'd2
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_timeout
        $error("TIMEOUT must lie in 2..256 for the 8-bit wait counter");
    end

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                ack1_q, ack1_d;
    logic                ack2_q, ack2_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [DATA_W-1:0]   rdata2_q, rdata2_d;
    logic                terr_q, terr_d;

    logic                req1_live, req2_live;
    logic                grant1, grant2;
    logic                abort;

    // A lane still holds its request during its own ack cycle; that request is already served.
    assign req1_live = req1 & ~ack1_q;
    assign req2_live = req2 & ~ack2_q;

`ifdef DMEM_ARB_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    assign abort = ~mem_done && (wait_q == 8'(TIMEOUT - 1));

    always_comb begin
        wait_d = wait_q;
        if (state_q != IDLE && !mem_done) begin
            wait_d = wait_q + 8'd1;
        end
        if (grant1 || grant2) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack1_d      = 1'b0;
        ack2_d      = 1'b0;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        terr_d      = terr_q;
        grant1      = 1'b0;
        grant2      = 1'b0;

        case (state_q)
            IDLE: begin
                grant1 = req1_live;
                grant2 = ~req1_live & req2_live;
            end
            BUS1: begin
                if (mem_done || abort) begin
                    ack1_d = 1'b1;
                    if (!mem_we_q) begin
                        rdata1_d = mem_done ? mem_rdata : '0;
                    end
                    if (!mem_done) begin
                        terr_d = 1'b1;
                    end
                    // After lane 1 completes, a waiting lane 2 always takes the port next.
                    grant2 = req2_live;
                    if (!req2_live) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            BUS2: begin
                if (mem_done || abort) begin
                    ack2_d = 1'b1;
                    if (!mem_we_q) begin
                        rdata2_d = mem_done ? mem_rdata : '0;
                    end
                    if (!mem_done) begin
                        terr_d = 1'b1;
                    end
                    grant1 = req1_live;
                    if (!req1_live) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (grant1) begin
            state_d     = BUS1;
            mem_req_d   = 1'b1;
            mem_we_d    = we1;
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
        end else if (grant2) begin
            state_d     = BUS2;
            mem_req_d   = 1'b1;
            mem_we_d    = we2;
            mem_addr_d  = addr2;
            mem_wdata_d = wdata2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack1_q      <= 1'b0;
            ack2_q      <= 1'b0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack1_q      <= ack1_d;
            ack2_q      <= ack2_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            terr_q      <= terr_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign ack1        = ack1_q;
    assign ack2        = ack2_q;
    assign rdata1      = rdata1_q;
    assign rdata2      = rdata2_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: lane drivers, memory responder, ack and memory-side monitors.
module tb_dmem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req1, we1, req2, we2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] wdata1, wdata2;
    logic          ack1, ack2;
    logic [DW-1:0] rdata1, rdata2;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_done;
    logic          busy, timeout_err;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .req2(req2), .we2(we2), .addr2(addr2), .wdata2(wdata2), .ack2(ack2), .rdata2(rdata2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        logic [31:0] rdata;
        int          lat;
        int          gap;
    } ack_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mtx_t;

    ack_t exp_q[$];
    mtx_t mq[$];
    mtx_t lq1[$];
    mtx_t lq2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start1 = 0;
    int start2 = 0;
    int last_ack = 0;
    int lat_cfg = 0;
    logic resp_en = 1'b1;
    logic force_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input int lane, input logic [31:0] rd, input int lat, input int gap);
        ack_t e;
        e.lane = lane; e.rdata = rd; e.lat = lat; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int lane, input logic we, input logic [31:0] a, input logic [31:0] d);
        mtx_t t;
        t.we = we; t.addr = a; t.wdata = d;
        mq.push_back(t);
        if (lane == 1) lq1.push_back(t);
        else lq2.push_back(t);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d acks outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Lane drivers: hold the front request until its ack has been seen, then present the next.
    logic a1, a2;
    initial begin
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        forever begin
            @(negedge clk); a1 = ack1;
            @(posedge clk); #1;
            if (rst) begin
                lq1.delete(); req1 = 1'b0;
            end else begin
                if (a1 && lq1.size() > 0) void'(lq1.pop_front());
                if (lq1.size() > 0) begin
                    if (!req1 || a1) start1 = cyc;
                    req1 = 1'b1; we1 = lq1[0].we; addr1 = lq1[0].addr; wdata1 = lq1[0].wdata;
                end else begin
                    req1 = 1'b0;
                end
            end
        end
    end

    initial begin
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
        forever begin
            @(negedge clk); a2 = ack2;
            @(posedge clk); #1;
            if (rst) begin
                lq2.delete(); req2 = 1'b0;
            end else begin
                if (a2 && lq2.size() > 0) void'(lq2.pop_front());
                if (lq2.size() > 0) begin
                    if (!req2 || a2) start2 = cyc;
                    req2 = 1'b1; we2 = lq2[0].we; addr2 = lq2[0].addr; wdata2 = lq2[0].wdata;
                end else begin
                    req2 = 1'b0;
                end
            end
        end
    end

    // Memory responder: completes after lat_cfg wait cycles; read data encodes address bits [15:8].
    int wait_c = 0;
    initial begin
        mem_done = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_done) wait_c = 0;
            if (mem_req) begin
                mem_rdata = {16'hA5A5, 8'h00, mem_addr[15:8]};
                mem_done = resp_en && (wait_c >= lat_cfg);
                if (!mem_done) wait_c++;
            end else begin
                mem_done = force_done;
                wait_c = 0;
            end
        end
    end

    // Monitor: pops expected acks and memory transactions as the DUT presents them.
    initial begin
        ack_t e;
        int lane;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (ack1 && ack2) begin
                checks++; errors++;
                $display("FAIL ack_exclusive: got ack1=1 ack2=1 expected at most one");
            end
            if (ack1 || ack2) begin
                lane = ack1 ? 1 : 2;
                rd = ack1 ? rdata1 : rdata2;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got ack on lane %0d expected none", lane);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_lane", lane, e.lane);
                    check("ack_rdata", rd, e.rdata);
                    if (e.lat > 0) check("ack_latency", cyc - (lane == 1 ? start1 : start2), e.lat);
                    if (e.gap > 0) check("ack_gap", cyc - last_ack, e.gap);
                end
                last_ack = cyc;
            end
            if (mem_req) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: got mem_req=1 addr %h expected idle port", mem_addr);
                end else begin
                    check("mem_we", mem_we, mq[0].we);
                    check("mem_addr", mem_addr, mq[0].addr);
                    check("mem_wdata", mem_wdata, mq[0].wdata);
                    if (mem_done) void'(mq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {ack1, ack2}, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;

        // single load, minimum latency
        lat_cfg = 0;
        expect_ack(1, 32'hA5A5_0001, 2, 0);
        issue(1, 1'b0, 32'h100, 32'h0);
        wait_drain(50);
        check("t1_busy_clear", busy, 0);
        check("t1_mem_req_clear", mem_req, 0);

        // simultaneous requests: lane 1 store first, lane 2 load back-to-back
        expect_ack(1, 32'hA5A5_0001, 2, 0);
        expect_ack(2, 32'hA5A5_0002, 0, 1);
        issue(1, 1'b1, 32'h200, 32'h11);
        issue(2, 1'b0, 32'h204, 32'h0);
        wait_drain(50);

        // fairness with both lanes re-requesting continuously
        expect_ack(1, 32'hA5A5_0005, 0, 0);
        expect_ack(2, 32'hA5A5_0008, 0, 0);
        expect_ack(1, 32'hA5A5_0006, 0, 0);
        expect_ack(2, 32'hA5A5_0009, 0, 0);
        expect_ack(1, 32'hA5A5_0007, 0, 0);
        expect_ack(2, 32'hA5A5_000A, 0, 0);
        issue(1, 1'b0, 32'h500, 32'h0);
        issue(2, 1'b0, 32'h800, 32'h0);
        issue(1, 1'b0, 32'h600, 32'h0);
        issue(2, 1'b0, 32'h900, 32'h0);
        issue(1, 1'b0, 32'h700, 32'h0);
        issue(2, 1'b0, 32'hA00, 32'h0);
        wait_drain(100);

        // slow memory: payload stable while waiting, one ack, stale request not re-granted
        lat_cfg = 5;
        expect_ack(1, 32'hA5A5_0003, 7, 0);
        issue(1, 1'b0, 32'h300, 32'h0);
        wait_drain(50);
        check("t4_no_regrant", busy, 0);
        lat_cfg = 3;
        expect_ack(2, 32'hA5A5_000A, 5, 0);
        issue(2, 1'b1, 32'h400, 32'hDEAD_BEEF);
        wait_drain(50);
        lat_cfg = 0;

        // reset while lane 2 is being served
        resp_en = 1'b0;
        issue(2, 1'b0, 32'hB00, 32'h0);
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        check("t5_busy_before_rst", busy, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_mem_req", mem_req, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ack2", ack2, 0);
        check("t5_rst_mem_addr", mem_addr, 0);
        check("t5_rst_rdata2", rdata2, 0);
        mq.delete();
        @(posedge clk); #3 rst = 1'b0;
        resp_en = 1'b1;
        force_done = 1'b1;
        repeat (3) @(negedge clk);
        force_done = 1'b0;
        check("t5_done_ignored_busy", busy, 0);
        check("t5_done_ignored_req", mem_req, 0);
        expect_ack(2, 32'hA5A5_000D, 2, 0);
        issue(2, 1'b0, 32'hD00, 32'h0);
        wait_drain(50);

`ifdef DMEM_ARB_TIMEOUT_EN
        // memory never answers: abort after TO cycles of mem_req
        resp_en = 1'b0;
        expect_ack(1, 32'h0, TO + 1, 0);
        issue(1, 1'b0, 32'hC00, 32'h0);
        wait_drain(60);
        mq.delete();
        resp_en = 1'b1;
        check("t6_timeout_err", timeout_err, 1);
        expect_ack(2, 32'hA5A5_000E, 2, 0);
        issue(2, 1'b0, 32'hE00, 32'h0);
        wait_drain(50);
        check("t6_timeout_sticky", timeout_err, 1);
`else
        check("timeout_err_tied", timeout_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
